// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths and grant encoding for the register-file write-port arbiter
package rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_WB    = 2'd1,
    GNT_FIFO  = 2'd2,
    GNT_FORCE = 2'd3
  } grant_e;
endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - circular buffer of queued LLU {rd, data} results
// Per-entry valid/rd vectors are exported so decode can detect pending writes.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  push_i,
  input  reg_addr_t                             push_rd_i,
  input  xlen_t                                 push_data_i,
  input  logic                                  pop_i,
  output reg_addr_t                             head_rd_o,
  output xlen_t                                 head_data_o,
  output logic [CW-1:0]                         count_o,
  output logic [CW-1:0]                         count_next_o,
  output logic [DEPTH-1:0]                      ent_valid_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      ent_rd_o
);

  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem_q;
  logic [DEPTH-1:0][XLEN-1:0]       data_mem_q;
  logic [DEPTH-1:0]                 valid_q, valid_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;

  // Pop is applied before push so a full FIFO can swap its head in one cycle.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + AW'(1);
    end
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_i;
      data_mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_rd_o    = rd_mem_q[rd_ptr_q];
  assign head_data_o  = data_mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign ent_valid_o  = valid_q;
  assign ent_rd_o     = rd_mem_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// rtl/regfile_wport_arbiter.sv - shares the register-file write port between WB and a queued LLU
// WB has priority; a starvation counter forces an LLU drain after STARVE_LIMIT blocked cycles.
module regfile_wport_arbiter
  import rf_pkg::*;
#(
  parameter  int DEPTH        = 2,
  parameter  int STARVE_LIMIT = 4,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  wb_stall,
  input  logic                  llu_valid,
  output logic                  llu_ready,
  input  logic [REG_ADDR_W-1:0] llu_rd,
  input  logic [XLEN-1:0]       llu_data,
  output logic                  rf_reg_write,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_write_data,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  pend_rs1,
  output logic                  pend_rs2,
  output logic [CW-1:0]         fifo_count
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic                             llu_ready_q;
  logic                             rf_reg_write_q, rf_reg_write_d;
  reg_addr_t                        rf_rd_q, rf_rd_d;
  xlen_t                            rf_write_data_q, rf_write_data_d;
  logic [3:0]                       starve_q, starve_d;
  grant_e                           grant;
  logic                             wb_req, fifo_ne, fifo_push, fifo_pop;
  reg_addr_t                        head_rd;
  xlen_t                            head_data;
  logic [CW-1:0]                    count_next;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_rd;

  assign wb_req    = wb_valid && (wb_rd != '0);
  assign fifo_ne   = (fifo_count != '0);
  // x0 results complete the handshake but never occupy an entry.
  assign fifo_push = llu_valid && llu_ready_q && (llu_rd != '0);
  assign fifo_pop  = (grant == GNT_FORCE) || (grant == GNT_FIFO);

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .push_i       (fifo_push),
    .push_rd_i    (llu_rd),
    .push_data_i  (llu_data),
    .pop_i        (fifo_pop),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (fifo_count),
    .count_next_o (count_next),
    .ent_valid_o  (ent_valid),
    .ent_rd_o     (ent_rd)
  );

  always_comb begin
    grant    = GNT_IDLE;
    wb_stall = 1'b0;
    if (fifo_ne && (starve_q == STARVE_MAX)) begin
      grant    = GNT_FORCE;
      wb_stall = wb_req;
    end else if (wb_req) begin
      grant = GNT_WB;
    end else if (fifo_ne) begin
      grant = GNT_FIFO;
    end
  end

  always_comb begin
    rf_reg_write_d  = 1'b0;
    rf_rd_d         = rf_rd_q;
    rf_write_data_d = rf_write_data_q;
    case (grant)
      GNT_WB: begin
        rf_reg_write_d  = 1'b1;
        rf_rd_d         = wb_rd;
        rf_write_data_d = wb_data;
      end
      GNT_FIFO, GNT_FORCE: begin
        rf_reg_write_d  = 1'b1;
        rf_rd_d         = head_rd;
        rf_write_data_d = head_data;
      end
      default: ;
    endcase

    starve_d = starve_q;
    if (!fifo_ne || fifo_pop) begin
      starve_d = '0;
    end else if ((grant == GNT_WB) && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      llu_ready_q     <= 1'b0;
      rf_reg_write_q  <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
      starve_q        <= '0;
    end else begin
      llu_ready_q     <= (count_next < CW'(DEPTH));
      rf_reg_write_q  <= rf_reg_write_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
      starve_q        <= starve_d;
    end
  end

  // A write on rf_* is still pending until the register file commits it on negedge.
  always_comb begin
    pend_rs1 = rf_reg_write_q && (rf_rd_q == rs1);
    pend_rs2 = rf_reg_write_q && (rf_rd_q == rs2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == rs1)) pend_rs1 = 1'b1;
      if (ent_valid[i] && (ent_rd[i] == rs2)) pend_rs2 = 1'b1;
    end
    if (rs1 == '0) pend_rs1 = 1'b0;
    if (rs2 == '0) pend_rs2 = 1'b0;
  end

  assign llu_ready     = llu_ready_q;
  assign rf_reg_write  = rf_reg_write_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;

endmodule
